// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared constants for the ID-stage forwarding/hazard unit and the EX-stage operand muxes.
// Forwarding-select codes, FSM state encoding and default widths live here.
package forwarding_hazard_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_W      = 2;

    typedef logic [1:0] fwd_sel_t;

    // Select codes shared with the EX-stage operand muxes
    localparam fwd_sel_t FWD_ORIGINAL = 2'b00;  // register-file value
    localparam fwd_sel_t FWD_MEM      = 2'b01;  // Write_Data_WB
    localparam fwd_sel_t FWD_EX       = 2'b10;  // ALU_Result_MEM

    typedef enum logic {
        StRun     = 1'b0,
        StLuStall = 1'b1
    } hz_state_e;

endpackage

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// fwd_select: next forwarding select for one source operand.
// The EX-stage producer is younger than the MEM-stage one, so it wins.
module forwarding_hazard_unit_fwd_select #(
    parameter int unsigned REG_ADDR_W = forwarding_hazard_unit_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] i_src_reg,
    input  logic                  i_use_src,
    input  logic [REG_ADDR_W-1:0] i_write_reg_ex,
    input  logic                  i_reg_write_ex,
    input  logic [REG_ADDR_W-1:0] i_write_reg_mem,
    input  logic                  i_reg_write_mem,
    output logic [1:0]            o_fwd_sel
);
    import forwarding_hazard_unit_pkg::*;

    logic w_ex_hit;
    logic w_mem_hit;

    // Register 0 is hard-wired zero and never forwarded
    assign w_ex_hit  = i_use_src && i_reg_write_ex && (i_write_reg_ex != '0)
                       && (i_write_reg_ex == i_src_reg);
    assign w_mem_hit = i_use_src && i_reg_write_mem && (i_write_reg_mem != '0)
                       && (i_write_reg_mem == i_src_reg);

    // Priority pick: EX producer first, then MEM producer, else register file
    always_comb begin
        o_fwd_sel = FWD_ORIGINAL;
        if (w_ex_hit) begin
            o_fwd_sel = FWD_EX;
        end else if (w_mem_hit) begin
            o_fwd_sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// ID-stage forwarding and load-use hazard unit.
// Registers the EX forwarding selects and raises a one-cycle stall/bubble on a load-use
// dependency. Hold freezes everything; Flush squashes the ID instruction.
// Optional build macro STALL_COUNT_EN adds a 32-bit stall-cycle counter output.
module forwarding_hazard_unit #(
    parameter int unsigned REG_ADDR_W = forwarding_hazard_unit_pkg::REG_ADDR_W,
    parameter int unsigned FWD_W      = forwarding_hazard_unit_pkg::FWD_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_rs_id,
    input  logic [REG_ADDR_W-1:0] i_rt_id,
    input  logic                  i_use_rs_id,
    input  logic                  i_use_rt_id,
    input  logic [REG_ADDR_W-1:0] i_write_reg_ex,
    input  logic                  i_reg_write_ex,
    input  logic                  i_mem_read_ex,
    input  logic [REG_ADDR_W-1:0] i_write_reg_mem,
    input  logic                  i_reg_write_mem,
    input  logic                  i_hold,
    input  logic                  i_flush,
    output logic [FWD_W-1:0]      o_forward_a,
    output logic [FWD_W-1:0]      o_forward_b,
    output logic                  o_stall,
    output logic                  o_id_ex_bubble
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]           o_stall_count
`endif
);
    import forwarding_hazard_unit_pkg::*;

    hz_state_e r_state;
    fwd_sel_t  r_fwd_a;
    fwd_sel_t  r_fwd_b;

    fwd_sel_t  w_next_a;
    fwd_sel_t  w_next_b;
    logic      w_load_use;

    forwarding_hazard_unit_fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_select_a (
        .i_src_reg       (i_rs_id),
        .i_use_src       (i_use_rs_id),
        .i_write_reg_ex  (i_write_reg_ex),
        .i_reg_write_ex  (i_reg_write_ex),
        .i_write_reg_mem (i_write_reg_mem),
        .i_reg_write_mem (i_reg_write_mem),
        .o_fwd_sel       (w_next_a)
    );

    forwarding_hazard_unit_fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_select_b (
        .i_src_reg       (i_rt_id),
        .i_use_src       (i_use_rt_id),
        .i_write_reg_ex  (i_write_reg_ex),
        .i_reg_write_ex  (i_reg_write_ex),
        .i_write_reg_mem (i_write_reg_mem),
        .i_reg_write_mem (i_reg_write_mem),
        .o_fwd_sel       (w_next_b)
    );

    // A load in EX whose result the ID instruction needs cannot be forwarded in time
    assign w_load_use = i_mem_read_ex && i_reg_write_ex && (i_write_reg_ex != '0)
                        && ((i_use_rs_id && (i_write_reg_ex == i_rs_id))
                            || (i_use_rt_id && (i_write_reg_ex == i_rt_id)));

    // Hold suppresses both strobes; flush alone still bubbles ID/EX
    always_comb begin
        o_stall        = 1'b0;
        o_id_ex_bubble = 1'b0;
        if (!i_hold) begin
            if (i_flush) begin
                o_id_ex_bubble = 1'b1;
            end else if ((r_state == StRun) && w_load_use) begin
                o_stall        = 1'b1;
                o_id_ex_bubble = 1'b1;
            end
        end
    end

    // FSM with registered forwarding selects
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StRun;
            r_fwd_a <= FWD_ORIGINAL;
            r_fwd_b <= FWD_ORIGINAL;
        end else if (!i_hold) begin
            if (i_flush) begin
                r_state <= StRun;
                r_fwd_a <= FWD_ORIGINAL;
                r_fwd_b <= FWD_ORIGINAL;
            end else begin
                unique case (r_state)
                    StRun: begin
                        if (w_load_use) begin
                            // Bubble goes to EX; selects must not point at stale producers
                            r_state <= StLuStall;
                            r_fwd_a <= FWD_ORIGINAL;
                            r_fwd_b <= FWD_ORIGINAL;
                        end else begin
                            r_state <= StRun;
                            r_fwd_a <= w_next_a;
                            r_fwd_b <= w_next_b;
                        end
                    end
                    StLuStall: begin
                        // Load has reached MEM, so re-evaluated selects pick WB data
                        r_state <= StRun;
                        r_fwd_a <= w_next_a;
                        r_fwd_b <= w_next_b;
                    end
                    default: begin
                        r_state <= StRun;
                        r_fwd_a <= FWD_ORIGINAL;
                        r_fwd_b <= FWD_ORIGINAL;
                    end
                endcase
            end
        end
    end

    assign o_forward_a = FWD_W'(r_fwd_a);
    assign o_forward_b = FWD_W'(r_fwd_b);

`ifdef STALL_COUNT_EN
    logic [31:0] r_stall_count;

    // Count stall cycles, wrapping naturally at 2^32
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_count <= 32'd0;
        end else if (o_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_forwarding_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs = '0, rt = '0, wr_ex = '0, wr_mem = '0;
    logic       use_rs = 1'b0, use_rt = 1'b0;
    logic       rw_ex = 1'b0, mr_ex = 1'b0, rw_mem = 1'b0;
    logic       hold = 1'b0, flush = 1'b0;
    logic [1:0] fa, fb;
    logic       stall, bubble;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model state: registered selects, "previous cycle was a load-use stall", stall count
    logic [1:0]  m_fa = 2'b00;
    logic [1:0]  m_fb = 2'b00;
    logic        m_stalled = 1'b0;
    logic [31:0] m_cnt = 32'd0;

    always #5 clk = ~clk;

    forwarding_hazard_unit dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rs_id         (rs),
        .i_rt_id         (rt),
        .i_use_rs_id     (use_rs),
        .i_use_rt_id     (use_rt),
        .i_write_reg_ex  (wr_ex),
        .i_reg_write_ex  (rw_ex),
        .i_mem_read_ex   (mr_ex),
        .i_write_reg_mem (wr_mem),
        .i_reg_write_mem (rw_mem),
        .i_hold          (hold),
        .i_flush         (flush),
        .o_forward_a     (fa),
        .o_forward_b     (fb),
        .o_stall         (stall),
        .o_id_ex_bubble  (bubble)
`ifdef STALL_COUNT_EN
        ,
        .o_stall_count   (stall_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which stage, if any, holds the youngest non-zero producer of src
    function automatic logic [1:0] m_sel(input logic [4:0] src, input logic use_src);
        if (!use_src || src == 5'd0) return 2'b00;
        if (rw_ex && wr_ex == src) return 2'b10;
        if (rw_mem && wr_mem == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lu();
        return mr_ex && rw_ex && (wr_ex != 5'd0)
               && ((use_rs && wr_ex == rs) || (use_rt && wr_ex == rt));
    endfunction

    function automatic logic m_stall();
        return !hold && !flush && !m_stalled && m_lu();
    endfunction

    function automatic logic m_bubble();
        return !hold && (flush || (!m_stalled && m_lu()));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fa <= 2'b00;
            m_fb <= 2'b00;
            m_stalled <= 1'b0;
            m_cnt <= 32'd0;
        end else if (!hold) begin
            if (m_stall()) m_cnt <= m_cnt + 32'd1;
            if (flush) begin
                m_fa <= 2'b00;
                m_fb <= 2'b00;
                m_stalled <= 1'b0;
            end else if (m_stall()) begin
                m_fa <= 2'b00;
                m_fb <= 2'b00;
                m_stalled <= 1'b1;
            end else begin
                m_fa <= m_sel(rs, use_rs);
                m_fb <= m_sel(rt, use_rt);
                m_stalled <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_fwd_a", {30'd0, fa}, {30'd0, m_fa});
        check("cmp_fwd_b", {30'd0, fb}, {30'd0, m_fb});
        check("cmp_stall", {31'd0, stall}, {31'd0, m_stall()});
        check("cmp_bubble", {31'd0, bubble}, {31'd0, m_bubble()});
`ifdef STALL_COUNT_EN
        check("cmp_stall_count", stall_count, m_cnt);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) step();
        check("rst_fwd_a", {30'd0, fa}, 32'd0);
        check("rst_fwd_b", {30'd0, fb}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;

        // EX->EX forward on Rt
        rw_ex = 1; wr_ex = 5'd3; rt = 5'd3; use_rt = 1; rs = 5'd7; use_rs = 1;
        #1 check("exex_stall", {31'd0, stall}, 32'd0);
        step();
        check("exex_fwd_b", {30'd0, fb}, 32'd2);
        check("exex_fwd_a", {30'd0, fa}, 32'd0);

        // Double match: EX beats MEM, then MEM alone
        wr_ex = 5'd5; rw_mem = 1; wr_mem = 5'd5; rs = 5'd5; rt = 5'd9;
        step();
        check("dbl_fwd_a_ex", {30'd0, fa}, 32'd2);
        rw_ex = 0;
        step();
        check("dbl_fwd_a_mem", {30'd0, fa}, 32'd1);

        // Load-use on Rt
        rw_ex = 1; mr_ex = 1; wr_ex = 5'd8; rt = 5'd8; rs = 5'd1; rw_mem = 0;
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_bubble", {31'd0, bubble}, 32'd1);
        step();
        check("lu_fwd_b_bubble", {30'd0, fb}, 32'd0);
        rw_ex = 0; mr_ex = 0; rw_mem = 1; wr_mem = 5'd8;
        #1 check("lu2_stall", {31'd0, stall}, 32'd0);
        check("lu2_bubble", {31'd0, bubble}, 32'd0);
        step();
        check("lu_fwd_b_mem", {30'd0, fb}, 32'd1);

        // $zero never forwards or stalls
        rw_mem = 0; rw_ex = 1; mr_ex = 1; wr_ex = 5'd0; rs = 5'd0; rt = 5'd2;
        #1 check("zero_stall", {31'd0, stall}, 32'd0);
        step();
        check("zero_fwd_a", {30'd0, fa}, 32'd0);

        // Hold freezes selects while a load-use is presented
        mr_ex = 0; wr_ex = 5'd4; rt = 5'd4; rs = 5'd1;
        step();
        check("hold_pre_fwd_b", {30'd0, fb}, 32'd2);
        hold = 1; mr_ex = 1; wr_ex = 5'd6; rs = 5'd6;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", {31'd0, stall}, 32'd0);
            check("hold_bubble", {31'd0, bubble}, 32'd0);
            step();
            check("hold_fwd_b", {30'd0, fb}, 32'd2);
        end

        // Flush beats load-use
        hold = 0; flush = 1;
        #1 check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_bubble", {31'd0, bubble}, 32'd1);
        step();
        check("flush_fwd_a", {30'd0, fa}, 32'd0);
        check("flush_fwd_b", {30'd0, fb}, 32'd0);

        // Hold and flush together: hold wins
        flush = 0; mr_ex = 0; wr_ex = 5'd4; rt = 5'd4;
        step();
        check("hf_pre_fwd_b", {30'd0, fb}, 32'd2);
        hold = 1; flush = 1;
        #1 check("hf_bubble", {31'd0, bubble}, 32'd0);
        step();
        check("hf_fwd_b", {30'd0, fb}, 32'd2);
        hold = 0; flush = 0;

        // Reset while in the load-use stall cycle
        mr_ex = 1; rw_ex = 1; wr_ex = 5'd8; rt = 5'd8; use_rt = 1;
        #1 check("rs_lu_stall", {31'd0, stall}, 32'd1);
        step();
        #1 check("rs_in_stall_cycle", {31'd0, stall}, 32'd0);
        #1 rst_n = 0;
        #1 check("rs_fwd_a", {30'd0, fa}, 32'd0);
        check("rs_fwd_b", {30'd0, fb}, 32'd0);
        check("rs_stall_run", {31'd0, stall}, 32'd1);
`ifdef STALL_COUNT_EN
        check("rs_stall_count", stall_count, 32'd0);
`endif
        step();
        rst_n = 1;

        // Mixed traffic over a small register space, checked by the model every cycle
        for (int i = 0; i < 80; i++) begin
            rs     = 5'($urandom_range(0, 3));
            rt     = 5'($urandom_range(0, 3));
            use_rs = 1'($urandom_range(0, 1));
            use_rt = 1'($urandom_range(0, 1));
            wr_ex  = 5'($urandom_range(0, 3));
            rw_ex  = 1'($urandom_range(0, 1));
            mr_ex  = 1'($urandom_range(0, 1));
            wr_mem = 5'($urandom_range(0, 3));
            rw_mem = 1'($urandom_range(0, 1));
            hold   = ($urandom_range(0, 7) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            step();
        end

        hold = 0; flush = 0; rw_ex = 0; mr_ex = 0; rw_mem = 0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
